// File: rtl/sfp_link_pkg.sv
// sfp_link_pkg: state encoding and rate-select constants shared by the SFP+ link manager.
package sfp_link_pkg;

    typedef enum logic [2:0] {
        ABSENT       = 3'd0,
        DEBOUNCE     = 3'd1,
        INIT         = 3'd2,
        RESET_GT     = 3'd3,
        WAIT_SYNC    = 3'd4,
        LINK_UP      = 3'd5,
        FAULT_CLEAR  = 3'd6,
        FAULT_LOCKED = 3'd7
    } linkState_e;

    localparam logic [1:0] RS_OFF = 2'b00;
    localparam logic [1:0] RS_10G = 2'b11;

    // Larger of two timing parameters; used to size the shared down-counter.
    function automatic int maxOf(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sfp_input_sync.sv
// sfp_input_sync: parameterised-width two-flop synchroniser for the SFP/GT status pins.
module sfp_input_sync #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // First stage may go metastable; the second stage gives it a full cycle to settle.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            meta_q <= RESET_VALUE;
            sync_q <= RESET_VALUE;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/sfp_link_manager.sv
// sfp_link_manager: bring-up and supervision sequencer for the SFP+ 10GBASE-R port.
// Owns the laser disable, rate select and GT soft resets; all outputs are registered.
module sfp_link_manager
    import sfp_link_pkg::*;
#(
    parameter int         DEBOUNCE_CYCLES     = 1250000,
    parameter int         INIT_CYCLES         = 37500000,
    parameter int         RESET_PULSE_CYCLES  = 1250,
    parameter int         SYNC_TIMEOUT_CYCLES = 12500000,
    parameter int         FAULT_PULSE_CYCLES  = 1250,
    parameter int         MAX_RETRIES         = 3,
    parameter logic [1:0] RATE_SELECT         = RS_10G
) (
    input  logic       clk_125mhz,
    input  logic       rst_n,
    input  logic       sfp_mod_abs,
    input  logic       sfp_tx_fault,
    input  logic       sfp_rx_los,
    input  logic       qpll_lock,
    input  logic       block_sync_good,
    input  logic       retry,
    output logic       sfp_tx_disable,
    output logic [1:0] sfp_rs,
    output logic       gt_soft_reset_tx,
    output logic       gt_soft_reset_rx,
    output logic       link_ok,
    output logic [2:0] state,
    output logic [1:0] retry_count,
    output logic [7:0] link_drop_count
);

    localparam int MAX_TIMING = maxOf(maxOf(maxOf(DEBOUNCE_CYCLES, INIT_CYCLES),
                                            maxOf(RESET_PULSE_CYCLES, SYNC_TIMEOUT_CYCLES)),
                                      FAULT_PULSE_CYCLES);
    localparam int TIMER_W = $clog2(MAX_TIMING) + 1;

    logic [4:0] asyncIn;
    logic [4:0] syncIn;
    logic       modAbs;
    logic       txFault;
    logic       rxLos;
    logic       qpllLock;
    logic       blockSync;

    linkState_e         state_q,         state_d;
    logic [TIMER_W-1:0] timer_q,         timer_d;
    logic [1:0]         retryCount_q,    retryCount_d;
    logic [7:0]         linkDropCount_q, linkDropCount_d;

    logic       txDisable_q, txDisable_d;
    logic [1:0] rs_q,        rs_d;
    logic       gtReset_q,   gtReset_d;
    logic       linkOk_q,    linkOk_d;

    logic       timerDone;
    logic       linkHealthy;
    logic [1:0] retryInc;
    logic [7:0] dropInc;
    linkState_e faultTarget;
    linkState_e timeoutTarget;

    assign asyncIn = {sfp_mod_abs, sfp_tx_fault, sfp_rx_los, qpll_lock, block_sync_good};

    sfp_input_sync #(
        .WIDTH       (5),
        .RESET_VALUE (5'b10000)
    ) u_inputSync (
        .clk_i   (clk_125mhz),
        .rst_ni  (rst_n),
        .async_i (asyncIn),
        .sync_o  (syncIn)
    );

    assign modAbs    = syncIn[4];
    assign txFault   = syncIn[3];
    assign rxLos     = syncIn[2];
    assign qpllLock  = syncIn[1];
    assign blockSync = syncIn[0];

    assign timerDone     = (timer_q == '0);
    assign linkHealthy   = qpllLock & blockSync & ~rxLos;
    assign retryInc      = (retryCount_q == 2'b11) ? 2'b11 : retryCount_q + 2'd1;
    assign dropInc       = (linkDropCount_q == 8'hFF) ? 8'hFF : linkDropCount_q + 8'd1;
    assign faultTarget   = (int'(retryInc) >= MAX_RETRIES) ? FAULT_LOCKED : FAULT_CLEAR;
    assign timeoutTarget = (int'(retryInc) >= MAX_RETRIES) ? FAULT_LOCKED : RESET_GT;

    // Residence time of a state, minus one because the entry cycle itself counts.
    function automatic logic [TIMER_W-1:0] timerLoad(input linkState_e s);
        logic [TIMER_W-1:0] v;
        v = '0;
        case (s)
            DEBOUNCE:    v = TIMER_W'(DEBOUNCE_CYCLES - 1);
            INIT:        v = TIMER_W'(INIT_CYCLES - 1);
            RESET_GT:    v = TIMER_W'(RESET_PULSE_CYCLES - 1);
            WAIT_SYNC:   v = TIMER_W'(SYNC_TIMEOUT_CYCLES - 1);
            FAULT_CLEAR: v = TIMER_W'(FAULT_PULSE_CYCLES - 1);
            default:     v = '0;
        endcase
        return v;
    endfunction

    // Next-state, retry/drop bookkeeping and shared timer; removal beats fault beats timeout beats sync.
    always_comb begin
        state_d         = state_q;
        retryCount_d    = retryCount_q;
        linkDropCount_d = linkDropCount_q;
        if (modAbs && (state_q != ABSENT)) begin
            state_d = ABSENT;
            if (state_q == LINK_UP) begin
                linkDropCount_d = dropInc;
            end
        end else begin
            case (state_q)
                ABSENT: begin
                    if (!modAbs) begin
                        state_d = DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (timerDone) begin
                        state_d = INIT;
                    end
                end
                INIT: begin
                    if (timerDone) begin
                        state_d = RESET_GT;
                    end
                end
                RESET_GT: begin
                    if (txFault) begin
                        retryCount_d = retryInc;
                        state_d      = faultTarget;
                    end else if (timerDone) begin
                        state_d = WAIT_SYNC;
                    end
                end
                WAIT_SYNC: begin
                    if (txFault) begin
                        retryCount_d = retryInc;
                        state_d      = faultTarget;
                    end else if (timerDone) begin
                        retryCount_d = retryInc;
                        state_d      = timeoutTarget;
                    end else if (linkHealthy) begin
                        retryCount_d = 2'd0;
                        state_d      = LINK_UP;
                    end
                end
                LINK_UP: begin
                    if (txFault) begin
                        retryCount_d    = retryInc;
                        linkDropCount_d = dropInc;
                        state_d         = faultTarget;
                    end else if (!linkHealthy) begin
                        linkDropCount_d = dropInc;
                        state_d         = WAIT_SYNC;
                    end
                end
                FAULT_CLEAR: begin
                    if (timerDone) begin
                        state_d = txFault ? FAULT_LOCKED : WAIT_SYNC;
                    end
                end
                FAULT_LOCKED: begin
                    if (retry) begin
                        retryCount_d = 2'd0;
                        state_d      = INIT;
                    end
                end
                default: begin
                    state_d = ABSENT;
                end
            endcase
        end
        if (state_d != state_q) begin
            timer_d = timerLoad(state_d);
        end else if (timerDone) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q - TIMER_W'(1);
        end
    end

    // State register, shared timer and status counters.
    always_ff @(posedge clk_125mhz) begin
        if (!rst_n) begin
            state_q         <= ABSENT;
            timer_q         <= '0;
            retryCount_q    <= 2'd0;
            linkDropCount_q <= 8'd0;
        end else begin
            state_q         <= state_d;
            timer_q         <= timer_d;
            retryCount_q    <= retryCount_d;
            linkDropCount_q <= linkDropCount_d;
        end
    end

    // Output decode from the current state; laser stays off until the GT reset phase.
    always_comb begin
        txDisable_d = 1'b1;
        rs_d        = RATE_SELECT;
        gtReset_d   = 1'b1;
        linkOk_d    = 1'b0;
        case (state_q)
            ABSENT, DEBOUNCE: begin
                rs_d = RS_OFF;
            end
            RESET_GT: begin
                txDisable_d = 1'b0;
            end
            WAIT_SYNC: begin
                txDisable_d = 1'b0;
                gtReset_d   = 1'b0;
            end
            LINK_UP: begin
                txDisable_d = 1'b0;
                gtReset_d   = 1'b0;
                linkOk_d    = 1'b1;
            end
            FAULT_CLEAR: begin
                gtReset_d = 1'b0;
            end
            default: begin
                txDisable_d = 1'b1;
            end
        endcase
    end

    // Output registers, one cycle behind the state register so the pins are glitch-free.
    always_ff @(posedge clk_125mhz) begin
        if (!rst_n) begin
            txDisable_q <= 1'b1;
            rs_q        <= RS_OFF;
            gtReset_q   <= 1'b1;
            linkOk_q    <= 1'b0;
        end else begin
            txDisable_q <= txDisable_d;
            rs_q        <= rs_d;
            gtReset_q   <= gtReset_d;
            linkOk_q    <= linkOk_d;
        end
    end

    assign sfp_tx_disable   = txDisable_q;
    assign sfp_rs           = rs_q;
    assign gt_soft_reset_tx = gtReset_q;
    assign gt_soft_reset_rx = gtReset_q;
    assign link_ok          = linkOk_q;
    assign state            = state_q;
    assign retry_count      = retryCount_q;
    assign link_drop_count  = linkDropCount_q;

endmodule

// File: tb/tb_sfp_link_manager.sv
// tb_sfp_link_manager: randomized scenarios against a latency/counter model of the link manager.
module tb_sfp_link_manager;
    import sfp_link_pkg::*;

    localparam int DEB     = 16;
    localparam int INIT_C  = 32;
    localparam int RP      = 8;
    localparam int ST      = 64;
    localparam int FP      = 4;
    localparam int MAXR    = 3;
    // Drive-to-state latency: one edge to capture plus two synchroniser stages.
    localparam int IN_LAT  = 3;
    // Outputs are registered from the state, so they trail it by one cycle.
    localparam int OUT_LAT = 1;

    localparam int SEL_TXDIS = 0;
    localparam int SEL_LINK  = 1;
    localparam int SEL_GT    = 2;
    localparam int SEL_STATE = 3;

    logic       clk_125mhz = 1'b0;
    logic       rst_n;
    logic       sfp_mod_abs;
    logic       sfp_tx_fault;
    logic       sfp_rx_los;
    logic       qpll_lock;
    logic       block_sync_good;
    logic       retry;
    logic       sfp_tx_disable;
    logic [1:0] sfp_rs;
    logic       gt_soft_reset_tx;
    logic       gt_soft_reset_rx;
    logic       link_ok;
    logic [2:0] state;
    logic [1:0] retry_count;
    logic [7:0] link_drop_count;

    int totalChecks = 0;
    int badChecks   = 0;
    int modelDrops  = 0;
    int modelRetries = 0;

    sfp_link_manager #(
        .DEBOUNCE_CYCLES     (DEB),
        .INIT_CYCLES         (INIT_C),
        .RESET_PULSE_CYCLES  (RP),
        .SYNC_TIMEOUT_CYCLES (ST),
        .FAULT_PULSE_CYCLES  (FP),
        .MAX_RETRIES         (MAXR),
        .RATE_SELECT         (RS_10G)
    ) dut (
        .clk_125mhz       (clk_125mhz),
        .rst_n            (rst_n),
        .sfp_mod_abs      (sfp_mod_abs),
        .sfp_tx_fault     (sfp_tx_fault),
        .sfp_rx_los       (sfp_rx_los),
        .qpll_lock        (qpll_lock),
        .block_sync_good  (block_sync_good),
        .retry            (retry),
        .sfp_tx_disable   (sfp_tx_disable),
        .sfp_rs           (sfp_rs),
        .gt_soft_reset_tx (gt_soft_reset_tx),
        .gt_soft_reset_rx (gt_soft_reset_rx),
        .link_ok          (link_ok),
        .state            (state),
        .retry_count      (retry_count),
        .link_drop_count  (link_drop_count)
    );

    // 125 MHz-style free-running clock (10 time-unit period).
    always #5 clk_125mhz = ~clk_125mhz;

    // Hard stop in case a scenario wedges despite the bounded waits.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int satInc(input int v, input int maxv);
        return (v >= maxv) ? maxv : v + 1;
    endfunction

    function automatic logic [7:0] sigVal(input int sel);
        case (sel)
            SEL_TXDIS: return {7'd0, sfp_tx_disable};
            SEL_LINK:  return {7'd0, link_ok};
            SEL_GT:    return {7'd0, gt_soft_reset_tx};
            default:   return {5'd0, state};
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %0d, want %0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk_125mhz);
        #1;
    endtask

    task automatic applyStimulus(input logic modAbs, input logic txFault, input logic rxLos,
                                 input logic lock, input logic sync);
        sfp_mod_abs     = modAbs;
        sfp_tx_fault    = txFault;
        sfp_rx_los      = rxLos;
        qpll_lock       = lock;
        block_sync_good = sync;
    endtask

    task automatic waitFor(input int sel, input logic [7:0] target, input int limit, output int elapsed);
        elapsed = 0;
        while (sigVal(sel) !== target && elapsed < limit) begin
            tick();
            elapsed++;
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_state"}, 32'(state), 32'(ABSENT));
        checkOutput({tag, "_txdis"}, 32'(sfp_tx_disable), 32'd1);
        checkOutput({tag, "_rs"}, 32'(sfp_rs), 32'd0);
        checkOutput({tag, "_gtrst_tx"}, 32'(gt_soft_reset_tx), 32'd1);
        checkOutput({tag, "_gtrst_rx"}, 32'(gt_soft_reset_rx), 32'd1);
        checkOutput({tag, "_linkok"}, 32'(link_ok), 32'd0);
        checkOutput({tag, "_retries"}, 32'(retry_count), 32'd0);
        checkOutput({tag, "_drops"}, 32'(link_drop_count), 32'd0);
    endtask

    // Scenario sequence: each step predicts latencies and counters from the sequencing rules.
    initial begin
        int e;
        int n;
        int hold;
        int w;
        logic sawGt;
        logic sawFault;

        rst_n = 1'b0;
        retry = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        repeat (3) tick();
        checkResetValues("reset");
        rst_n = 1'b1;
        repeat ($urandom_range(2, 10)) tick();

        // Insertion from a clean start
        sfp_mod_abs = 1'b0;
        waitFor(SEL_TXDIS, 8'd0, 80, e);
        checkOutput("insert_txdis_fall", 32'(e), 32'(IN_LAT + DEB + INIT_C + OUT_LAT));
        checkOutput("insert_rs", 32'(sfp_rs), 32'(RS_10G));
        waitFor(SEL_LINK, 8'd1, 30, e);
        checkOutput("insert_linkok_rise", 32'(e), 32'(RP + 1));
        checkOutput("insert_retries", 32'(retry_count), 32'(modelRetries));
        checkOutput("insert_gtrst_tx", 32'(gt_soft_reset_tx), 32'd0);
        checkOutput("insert_gtrst_rx", 32'(gt_soft_reset_rx), 32'd0);

        // LOS drops in LINK_UP with random hold times; GT must not be reset
        n = $urandom_range(1, 3);
        for (int i = 0; i < n; i++) begin
            hold = $urandom_range(5, 40);
            sfp_rx_los = 1'b1;
            waitFor(SEL_LINK, 8'd0, 15, e);
            checkOutput("los_linkok_fall", 32'(e), 32'(IN_LAT + OUT_LAT));
            sawGt = 1'b0;
            for (int c = 0; c < hold; c++) begin
                tick();
                sawGt = sawGt | gt_soft_reset_tx | gt_soft_reset_rx;
            end
            checkOutput("los_gtrst_quiet", 32'(sawGt), 32'd0);
            modelDrops = satInc(modelDrops, 255);
            checkOutput("los_drops", 32'(link_drop_count), 32'(modelDrops));
            sfp_rx_los = 1'b0;
            waitFor(SEL_LINK, 8'd1, 15, e);
            checkOutput("los_linkok_rise", 32'(e), 32'(IN_LAT + OUT_LAT));
        end

        // Laser fault pulse in LINK_UP
        w = $urandom_range(1, 3);
        sfp_tx_fault = 1'b1;
        e = 0;
        while (sfp_tx_disable !== 1'b1 && e < 20) begin
            tick();
            e++;
            if (e == w) sfp_tx_fault = 1'b0;
        end
        sfp_tx_fault = 1'b0;
        checkOutput("fault_txdis_rise", 32'(e), 32'(IN_LAT + OUT_LAT));
        modelDrops   = satInc(modelDrops, 255);
        modelRetries = satInc(modelRetries, MAXR);
        checkOutput("fault_drops", 32'(link_drop_count), 32'(modelDrops));
        checkOutput("fault_retries", 32'(retry_count), 32'(modelRetries));
        waitFor(SEL_TXDIS, 8'd0, 20, e);
        checkOutput("fault_txdis_width", 32'(e), 32'(FP));
        waitFor(SEL_LINK, 8'd1, 20, e);
        checkOutput("fault_relink", 32'(e), 32'd1);
        modelRetries = 0;
        checkOutput("fault_relink_retries", 32'(retry_count), 32'(modelRetries));

        // A retry pulse outside FAULT_LOCKED has no effect
        retry = 1'b1;
        tick();
        retry = 1'b0;
        repeat (4) tick();
        checkOutput("retry_ignored_state", 32'(state), 32'(LINK_UP));
        checkOutput("retry_ignored_linkok", 32'(link_ok), 32'd1);

        // Block sync lost and never returns: timeouts re-reset the GT until locked out
        block_sync_good = 1'b0;
        modelDrops = satInc(modelDrops, 255);
        for (int a = 1; a < MAXR; a++) begin
            waitFor(SEL_GT, 8'd1, 100, e);
            checkOutput("nosync_gtrst_rise", 32'(e), (a == 1) ? 32'(IN_LAT + ST + OUT_LAT) : 32'(ST));
            modelRetries = satInc(modelRetries, MAXR);
            checkOutput("nosync_retries", 32'(retry_count), 32'(modelRetries));
            waitFor(SEL_GT, 8'd0, 20, e);
            checkOutput("nosync_gtrst_width", 32'(e), 32'(RP));
        end
        checkOutput("nosync_drops", 32'(link_drop_count), 32'(modelDrops));
        waitFor(SEL_TXDIS, 8'd1, 100, e);
        checkOutput("nosync_lock_time", 32'(e), 32'(ST));
        modelRetries = satInc(modelRetries, MAXR);
        checkOutput("locked_retries", 32'(retry_count), 32'(modelRetries));
        checkOutput("locked_gtrst", 32'(gt_soft_reset_tx), 32'd1);
        checkOutput("locked_linkok", 32'(link_ok), 32'd0);
        block_sync_good = 1'b1;
        repeat ($urandom_range(5, 30)) tick();
        checkOutput("locked_holds", 32'(state), 32'(FAULT_LOCKED));
        checkOutput("locked_txdis", 32'(sfp_tx_disable), 32'd1);
        retry = 1'b1;
        tick();
        retry = 1'b0;
        modelRetries = 0;
        checkOutput("retry_to_init", 32'(state), 32'(INIT));
        checkOutput("retry_clears_count", 32'(retry_count), 32'(modelRetries));
        waitFor(SEL_TXDIS, 8'd0, 60, e);
        checkOutput("retry_txdis_fall", 32'(e), 32'(INIT_C + OUT_LAT));
        waitFor(SEL_LINK, 8'd1, 30, e);
        checkOutput("retry_linkok_rise", 32'(e), 32'(RP + 1));

        // Many short LOS blips: drop counter must saturate rather than wrap
        for (int i = 0; i < 260; i++) begin
            sfp_rx_los = 1'b1;
            tick();
            sfp_rx_los = 1'b0;
            waitFor(SEL_LINK, 8'd0, 10, e);
            waitFor(SEL_LINK, 8'd1, 10, e);
            modelDrops = satInc(modelDrops, 255);
        end
        checkOutput("drops_saturate", 32'(link_drop_count), 32'(modelDrops));

        // Removal and laser fault in the same cycle: removal wins
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        e = 0;
        sawFault = 1'b0;
        while (state !== 3'(ABSENT) && e < 10) begin
            tick();
            e++;
            if (state == 3'(FAULT_CLEAR) || state == 3'(FAULT_LOCKED)) sawFault = 1'b1;
        end
        checkOutput("removal_to_absent", 32'(e), 32'(IN_LAT));
        checkOutput("removal_no_fault_path", 32'(sawFault), 32'd0);
        tick();
        sfp_tx_fault = 1'b0;
        checkOutput("removal_rs", 32'(sfp_rs), 32'(RS_OFF));
        checkOutput("removal_txdis", 32'(sfp_tx_disable), 32'd1);
        checkOutput("removal_linkok", 32'(link_ok), 32'd0);
        repeat (4) tick();

        // Bouncing insertion: debounce restarts from the final falling edge
        sfp_mod_abs = 1'b0;
        repeat ($urandom_range(3, 12)) tick();
        sfp_mod_abs = 1'b1;
        repeat ($urandom_range(1, 3)) tick();
        sfp_mod_abs = 1'b0;
        waitFor(SEL_STATE, 8'(INIT), 40, e);
        checkOutput("bounce_init_entry", 32'(e), 32'(IN_LAT + DEB));
        waitFor(SEL_LINK, 8'd1, 60, e);
        checkOutput("bounce_linkok_rise", 32'(e), 32'(INIT_C + RP + 1 + OUT_LAT));

        // Reset asserted mid WAIT_SYNC restores every reset value
        block_sync_good = 1'b0;
        waitFor(SEL_LINK, 8'd0, 15, e);
        checkOutput("sync_loss_linkok_fall", 32'(e), 32'(IN_LAT + OUT_LAT));
        repeat ($urandom_range(3, 20)) tick();
        rst_n = 1'b0;
        tick();
        checkResetValues("midreset");
        rst_n = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
